// File: rtl/mult_fu_pkg.sv
// Shared types for the multiplier unit and its CDB port.
// Tag width matches a 64-entry physical register file.
package mult_fu_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MULT_FUNC;

  localparam int TAG_W = 6;

  typedef logic [TAG_W-1:0] PHYS_REG_TAG;

  typedef struct packed {
    logic        valid;
    PHYS_REG_TAG tag;
    logic [31:0] data;
  } CDB_ENTRY;

  typedef struct packed {
    logic        valid;
    PHYS_REG_TAG tag;
    MULT_FUNC    func;
    logic [65:0] mcand;
    logic [32:0] mplier;
    logic [65:0] prod;
  } MULT_STAGE_PACKET;

endpackage

// File: rtl/mult_stage.sv
// One pipeline slice of the multiplier: accumulates the partial
// products for this stage's bits of the 33-bit multiplier.
module mult_stage
  import mult_fu_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  MULT_STAGE_PACKET in_pkt,
  output MULT_STAGE_PACKET out_pkt
);

  localparam int BITS = (33 + STAGES - 1) / STAGES;
  localparam int MAXB = BITS * STAGES;
  localparam int LO   = IDX * BITS;

  logic [MAXB-1:0] mp;
  logic [65:0]     acc;

  // Bit 32 is the multiplier sign, so its weight is -2^32.
  always_comb begin
    mp  = MAXB'(in_pkt.mplier);
    acc = in_pkt.prod;
    for (int i = 0; i < BITS; i++) begin
      if (mp[LO + i]) begin
        if (LO + i == 32) begin
          acc = acc - (in_pkt.mcand << 32);
        end else begin
          acc = acc + (in_pkt.mcand << (LO + i));
        end
      end
    end
    out_pkt      = in_pkt;
    out_pkt.prod = acc;
  end

endmodule

// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M multiplier feeding one CDB port.
// Results park in the done register until the CDB grants them.
module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  MULT_FUNC    issue_func,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  PHYS_REG_TAG issue_tag,
  input  logic        flush,
  output logic        cdb_request,
  input  logic        cdb_grant,
  output CDB_ENTRY    cdb_output
);

  MULT_STAGE_PACKET s   [STAGES];
  MULT_STAGE_PACKET nxt [STAGES];
  MULT_STAGE_PACKET issue_pkt;

  logic [STAGES-1:0] load;
  logic              sgn1;
  logic              sgn2;
  logic [32:0]       ext1;

  always_comb begin
    unique case (issue_func)
      MULH: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      MULHSU: begin
        sgn1 = 1'b1;
        sgn2 = 1'b0;
      end
      default: begin
        sgn1 = 1'b0;
        sgn2 = 1'b0;
      end
    endcase
    ext1             = {sgn1 & issue_rs1[31], issue_rs1};
    issue_pkt        = '0;
    issue_pkt.valid  = issue_valid;
    issue_pkt.tag    = issue_tag;
    issue_pkt.func   = issue_func;
    issue_pkt.mcand  = {{33{ext1[32]}}, ext1};
    issue_pkt.mplier = {sgn2 & issue_rs2[31], issue_rs2};
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_first
      mult_stage #(
        .STAGES(STAGES),
        .IDX   (g)
      ) u_stage (
        .in_pkt (issue_pkt),
        .out_pkt(nxt[g])
      );
    end else begin : g_rest
      mult_stage #(
        .STAGES(STAGES),
        .IDX   (g)
      ) u_stage (
        .in_pkt (s[g-1]),
        .out_pkt(nxt[g])
      );
    end
  end

  // A stage loads unless it and everything ahead of it is full and stuck.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      load[k] = cdb_grant;
      for (int j = k; j < STAGES; j++) begin
        load[k] = load[k] | ~s[j].valid;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        s[k].valid <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          s[k] <= nxt[k];
        end
      end
    end
  end

  assign issue_ready = load[0] & ~flush;

  always_comb begin
    cdb_request = ~flush & (s[STAGES-2].valid |
                            (s[STAGES-1].valid & ~cdb_grant));
    cdb_output  = '0;
    if (s[STAGES-1].valid && !flush) begin
      cdb_output.valid = 1'b1;
      cdb_output.tag   = s[STAGES-1].tag;
      cdb_output.data  = (s[STAGES-1].func == MUL) ?
                         s[STAGES-1].prod[31:0] :
                         s[STAGES-1].prod[63:32];
    end
  end

endmodule

// File: tb/tb_mult_fu.sv
// Bench for mult_fu: random multiplies scored against a queue
// of results computed with plain 64-bit arithmetic.
module tb_mult_fu;
  import mult_fu_pkg::*;

  localparam int STAGES = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  MULT_FUNC    issue_func;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  PHYS_REG_TAG issue_tag;
  logic        flush;
  logic        cdb_request;
  logic        cdb_grant;
  CDB_ENTRY    cdb_output;

  int total = 0;
  int bad   = 0;

  logic     o_ready;
  logic     o_req;
  CDB_ENTRY o_out;
  logic     prev_req = 1'b0;
  CDB_ENTRY exp_q [$];
  CDB_ENTRY exp_head;
  logic     head_ok;

  always #5 clock = ~clock;

  mult_fu #(.STAGES(STAGES)) dut (
    .clock      (clock),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_func (issue_func),
    .issue_rs1  (issue_rs1),
    .issue_rs2  (issue_rs2),
    .issue_tag  (issue_tag),
    .flush      (flush),
    .cdb_request(cdb_request),
    .cdb_grant  (cdb_grant),
    .cdb_output (cdb_output)
  );

  function automatic logic [31:0] ref_mult(input MULT_FUNC f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = (f == MULH || f == MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (f == MULH) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = sa * sb;
    return (f == MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: drive, sample mid-cycle, update the model, then step.
  task automatic cyc(input logic iv, input MULT_FUNC f,
                     input logic [31:0] a, input logic [31:0] b,
                     input PHYS_REG_TAG t, input logic fl,
                     input logic gr, input logic rst);
    CDB_ENTRY e;
    issue_valid = iv;
    issue_func  = f;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_tag   = t;
    flush       = fl;
    cdb_grant   = gr;
    reset       = rst;
    @(negedge clock);
    o_ready  = issue_ready;
    o_req    = cdb_request;
    o_out    = cdb_output;
    head_ok  = exp_q.size() > 0;
    exp_head = head_ok ? exp_q[0] : '0;
    if (rst || fl) begin
      exp_q.delete();
    end else begin
      if (o_out.valid && gr && head_ok) void'(exp_q.pop_front());
      if (iv && o_ready) begin
        e.valid = 1'b1;
        e.tag   = t;
        e.data  = ref_mult(f, a, b);
        exp_q.push_back(e);
      end
    end
    prev_req = rst ? 1'b0 : o_req;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic gr);
    cyc(1'b0, MUL, '0, '0, '0, 1'b0, gr, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, MUL, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, MUL, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", o_ready);
    end
    total++;
    if (o_req !== 1'b0) begin
      bad++; $display("FAIL reset_req got=%b want=0", o_req);
    end
    total++;
    if (o_out !== '0) begin
      bad++; $display("FAIL reset_out got=%h want=0", o_out);
    end
  endtask

  task automatic test_mul();
    CDB_ENTRY want;
    want = '{valid: 1'b1, tag: 6'd12, data: 32'd42};
    cyc(1'b1, MUL, 32'd7, 32'd6, 6'd12, 1'b0, 1'b0, 1'b0);
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL mul_ready got=%b want=1", o_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      idle(prev_req);
      if (c < 3) begin
        total++;
        if (o_req !== 1'b0) begin
          bad++; $display("FAIL mul_early_req c=%0d got=%b want=0", c, o_req);
        end
      end else if (c == 3) begin
        total++;
        if (o_req !== 1'b1) begin
          bad++; $display("FAIL mul_req_c3 got=%b want=1", o_req);
        end
      end else begin
        total++;
        if (o_out !== want) begin
          bad++; $display("FAIL mul_out_c4 got=%h want=%h", o_out, want);
        end
      end
    end
    idle(prev_req);
    total++;
    if (o_out.valid !== 1'b0) begin
      bad++; $display("FAIL mul_after got=%b want=0", o_out.valid);
    end
  endtask

  task automatic test_mulh();
    MULT_FUNC    fs [3];
    logic [31:0] ex [3];
    logic        seen;
    fs = '{MULH, MULHSU, MULHU};
    ex = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, PHYS_REG_TAG'(20 + i),
          1'b0, prev_req, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        idle(prev_req);
        if (o_out.valid) begin
          seen = 1'b1;
          total++;
          if (o_out.data !== ex[i] || o_out.tag !== PHYS_REG_TAG'(20 + i)) begin
            bad++;
            $display("FAIL mulh_%0d got=%h want=%h", i, o_out.data, ex[i]);
          end
        end
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL mulh_timeout_%0d got=none want=result", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nval  = 0;
    int first = -1;
    int last  = -1;
    for (int c = 0; c < 20; c++) begin
      cyc(c < 6, MUL, pick(), pick(), PHYS_REG_TAG'(c + 1), 1'b0, prev_req, 1'b0);
      if (c < 6) begin
        total++;
        if (o_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_ready c=%0d got=%b want=1", c, o_ready);
        end
      end
      if (o_out.valid) begin
        nval++;
        if (first < 0) first = c;
        last = c;
        total++;
        if (o_out !== exp_head) begin
          bad++; $display("FAIL b2b_out c=%0d got=%h want=%h", c, o_out, exp_head);
        end
      end
    end
    total++;
    if (nval != 6 || last - first != 5) begin
      bad++;
      $display("FAIL b2b_run got=%0d/%0d want=6/5", nval, last - first);
    end
  endtask

  task automatic test_backpressure();
    int       acc = 0;
    int       nout = 0;
    CDB_ENTRY held;
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, MULT_FUNC'($urandom_range(0, 3)), pick(), pick(),
          PHYS_REG_TAG'(40 + c), 1'b0, 1'b0, 1'b0);
      if (o_ready) acc++;
      else break;
    end
    total++;
    if (acc != STAGES) begin
      bad++; $display("FAIL bp_accepts got=%0d want=%0d", acc, STAGES);
    end
    held = o_out;
    total++;
    if (held !== exp_head || held.valid !== 1'b1) begin
      bad++; $display("FAIL bp_head got=%h want=%h", held, exp_head);
    end
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, MUL, pick(), pick(), 6'd63, 1'b0, 1'b0, 1'b0);
      total++;
      if (o_out !== held || o_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold c=%0d got=%h want=%h", c, o_out, held);
      end
    end
    for (int c = 0; c < 12; c++) begin
      idle(prev_req);
      if (o_out.valid) begin
        nout++;
        total++;
        if (o_out !== exp_head) begin
          bad++; $display("FAIL bp_drain got=%h want=%h", o_out, exp_head);
        end
      end
    end
    total++;
    if (nout != STAGES || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_count got=%0d want=%0d", nout, STAGES);
    end
  endtask

  task automatic test_random();
    logic gr;
    logic fl;
    int   n = 0;
    for (int c = 0; c < 300; c++) begin
      gr = prev_req & ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 49) == 0);
      cyc($urandom_range(0, 1) == 1, MULT_FUNC'($urandom_range(0, 3)),
          pick(), pick(), PHYS_REG_TAG'($urandom), fl, gr, 1'b0);
      if (fl) begin
        total++;
        if (o_req !== 1'b0 || o_out !== '0 || o_ready !== 1'b0) begin
          bad++; $display("FAIL rnd_flush c=%0d got=%b%b want=00", c, o_req, o_out.valid);
        end
      end else if (o_out.valid) begin
        total++;
        if (o_out !== exp_head) begin
          bad++; $display("FAIL rnd_out c=%0d got=%h want=%h", c, o_out, exp_head);
        end
      end
    end
    while (exp_q.size() > 0 && n < 60) begin
      idle(prev_req);
      if (o_out.valid) begin
        total++;
        if (o_out !== exp_head) begin
          bad++; $display("FAIL rnd_drain got=%h want=%h", o_out, exp_head);
        end
      end
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rnd_left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    int nval = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, MUL, pick(), pick(), PHYS_REG_TAG'(50 + c), 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, MUL, 32'd3, 32'd3, 6'd55, 1'b1, 1'b0, 1'b0);
    total++;
    if (o_req !== 1'b0 || o_out.valid !== 1'b0 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_cycle got=%b%b%b want=000", o_req, o_out.valid, o_ready);
    end
    idle(prev_req);
    total++;
    if (o_ready !== 1'b1) begin
      bad++; $display("FAIL flush_ready got=%b want=1", o_ready);
    end
    for (int c = 0; c < 10; c++) begin
      idle(prev_req);
      if (o_out.valid || o_req) nval++;
    end
    total++;
    if (nval != 0) begin
      bad++; $display("FAIL flush_leak got=%0d want=0", nval);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int c = 0; c < STAGES; c++) begin
      cyc(1'b1, MUL, pick(), pick(), PHYS_REG_TAG'(30 + c), 1'b0, 1'b0, 1'b0);
    end
    idle(prev_req);
    idle(prev_req);
    cyc(1'b0, MUL, '0, '0, '0, 1'b0, prev_req, 1'b1);
    idle(1'b0);
    total++;
    if (o_ready !== 1'b1 || o_req !== 1'b0 || o_out !== '0) begin
      bad++;
      $display("FAIL rst_mid got=%b%b%h want=10_0", o_ready, o_req, o_out);
    end
    cyc(1'b1, MULHSU, 32'h8000_0001, 32'h0001_0003, 6'd9, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= STAGES; c++) begin
      idle(prev_req);
      if (c == STAGES - 1) begin
        total++;
        if (o_req !== 1'b1) begin
          bad++; $display("FAIL rst_post_req got=%b want=1", o_req);
        end
      end else if (c == STAGES) begin
        total++;
        if (o_out !== exp_head || o_out.valid !== 1'b1) begin
          bad++; $display("FAIL rst_post_out got=%h want=%h", o_out, exp_head);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined RV32M multiplier functional unit. It sits directly upstream of the CDB arbiter and drives one `requests.mult` bit, consumes one `grants.mult` bit, and presents one `fu_outputs.mult` entry. It accepts an issued multiply, computes it over `STAGES` pipeline stages, and holds each completed result until the CDB grants it. Results are then removed from the unit with no loss and no duplication.

## Interface
- `STAGES`, default 4: number of pipeline registers, including the final "done" register; legal range 2..8.
- `clock` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `issue_valid` input 1: the issue register presents a multiply this cycle.
- `issue_ready` output 1: the unit can accept this cycle; the transfer happens when `issue_valid & issue_ready`.
- `issue_func` input `MULT_FUNC` (2 bits): MUL, MULH, MULHSU, MULHU.
- `issue_rs1`, `issue_rs2` input 32: operand values.
- `issue_tag` input `PHYS_REG_TAG`: destination physical register.
- `flush` input 1: mispredict recovery; discard all in-flight work.
- `cdb_request` output 1: this is the `requests.mult` bit to the CDB arbiter.
- `cdb_grant` input 1: this is the registered `grants.mult` bit from the CDB arbiter.
- `cdb_output` output `CDB_ENTRY`: contains `valid`, `tag` and `data`. The CDB muxes it using its registered grant bus.

## Operation
- Pipeline: registers s[0]..s[STAGES-1]. Each holds valid, tag, func, operands and the partial product. s[STAGES-1] is the done register.
- Arithmetic:
  - Operands are extended to 33 bits. rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only. The unsigned side is zero-extended.
  - The 66-bit two's-complement product is built incrementally. Each stage consumes ceil(33/STAGES) bits of the multiplier and shifts and accumulates the partial products.
  - Result: MUL returns product[31:0]; all other functions return product[63:32].
- Advance: s[k] loads from s[k-1] (s[0] loads from issue) when s[k] is empty or s[k] is itself advancing.
  - The done register advances when `~done.valid | cdb_grant`.
  - Bubbles collapse. A stalled done register does not block empty stages behind it.
- `issue_ready` = s[0] empty or s[0] advancing.
- `cdb_request` = done register will be valid in the next cycle:
  - With `cdb_grant` = 0: `done.valid | s[STAGES-2].valid`.
  - With `cdb_grant` = 1: `s[STAGES-2].valid`.
  - This sustains one grant per cycle with no double-grant.
- `cdb_output`:
  - valid = `done.valid`; tag and data come from the done register.
  - When the done register is empty, all fields are 0.
  - A granted entry leaves at the edge ending the grant cycle.
- `cdb_grant` while the done register is empty is legal and ignored; no state changes.
- Flush:
  - In the flush cycle, `cdb_request` = 0, `cdb_output` = '0 and `issue_ready` = 0.
  - At the edge, all valid bits clear. An issue presented in the flush cycle is dropped.
- Reset: all valid bits clear. Datapath contents are don't-care but must be masked by valid.

## Timing
- Reset values: `issue_ready` = 1, `cdb_request` = 0, `cdb_output` = '0.
- Latency with STAGES = 4 and the CDB idle:
  - Issue accepted in cycle 0.
  - s[0] in cycle 1, s[1] in cycle 2.
  - s[2] in cycle 3, with `cdb_request` = 1.
  - Done in cycle 4, with `cdb_grant` = 1 and `cdb_output.valid` = 1.
  - The CDB broadcasts in cycle 5.
- General latency: request in cycle STAGES-1, grant and output in cycle STAGES.
- Throughput: one result per cycle while grants are continuous.
- Back-pressure: with the grant held low, the unit holds up to STAGES results.
  - `issue_ready` falls when all stages are valid and the done register is not granted.
  - While held, `cdb_output` is stable.
- Simultaneous events:
  - A grant plus a new s[STAGES-2] entry in the same cycle causes the done register to be replaced in one edge.
  - Flush has priority over grant, issue and reset-free advance.
  - Reset has priority over everything.

## Structure
- `sys_defs.svh` owns the following; this block only uses them:
  - `MULT_FUNC` enum, `PHYS_REG_TAG`, `CDB_ENTRY`.
  - A `MULT_STAGE_PACKET` typedef covering the valid/tag/func/operands/partial-product bundle.
- Sub-module `mult_stage`: a combinational partial-product accumulate for one stage's bit slice, instantiated STAGES times.
- The top level owns the stage registers, advance logic, request logic, flush and result select.

## Test plan
- MUL with rs1 = 7, rs2 = 6, tag P12, grant returned each time it is requested:
  - `cdb_request` is high in cycle 3.
  - `cdb_output` = {1, P12, 42} in cycle 4.
- MULH, MULHSU and MULHU with rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF:
  - MULH returns 0x00000000.
  - MULHSU returns 0xFFFFFFFF.
  - MULHU returns 0xFFFFFFFE.
- Six back-to-back MULs with grant echoing request:
  - Six consecutive cycles of `cdb_output.valid`, tags in issue order.
  - `issue_ready` stays 1 throughout.
- Grant held 0 with issue continuous:
  - `issue_ready` drops after the STAGES-th accept.
  - `cdb_output` is unchanged while held.
  - When grant is released, all entries drain in order with none lost or duplicated.
- Flush with 3 entries in flight, one of them requesting:
  - `cdb_request` and `cdb_output.valid` are 0 in the flush cycle.
  - No further output appears.
  - `issue_ready` = 1 the next cycle.
- Reset asserted mid-drain:
  - Next cycle, all outputs equal their reset values.
  - A post-reset issue completes with the normal latency.
